// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiplier I/O path: FSM encodings,
// default UART timing and the element-count helper.
package matmul_pkg;

    localparam int unsigned DefaultClksPerBit = 10416;  // 100 MHz / 9600 baud

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    typedef enum logic [1:0] {
        LdIdle,
        LdLoadA,
        LdLoadB,
        LdDone
    } ld_state_e;

    function automatic int unsigned num_elems(input int unsigned rows, input int unsigned cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/uart_rx_mem_loader_if.sv
// Write-port and load-control bundle between the UART loader and the A/B
// input matrices.
interface uart_rx_mem_loader_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
);
    logic              load_en;
    logic              write_A;
    logic              write_B;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_value;
    logic              load_busy;
    logic              load_done;
    logic              frame_err;

    modport master (
        input  load_en,
        output write_A, write_B, write_address, write_value,
        output load_busy, load_done, frame_err
    );

    modport slave (
        output load_en,
        input  write_A, write_B, write_address, write_value,
        input  load_busy, load_done, frame_err
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer; mid-bit sampling,
// start-glitch rejection and a one-cycle frame-error pulse on a bad stop bit.
module uart_rx_byte
    import matmul_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err_pulse
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);

    logic [1:0]      sync_q;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= RxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_data};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RxIdle: begin
                cnt_d = '0;
                if (!rx_s) state_d = RxStart;
            end
            RxStart: begin
                // Re-check at mid start bit; a line already back high was a glitch.
                if (cnt_q == HalfEnd) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RxIdle : RxData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (cnt_q == BitEnd) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RxStop;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (cnt_q == BitEnd) begin
                    cnt_d   = '0;
                    state_d = RxIdle;
                    if (rx_s) valid_d = 1'b1;
                    else      ferr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    assign rx_byte         = shift_q;
    assign byte_valid      = valid_q;
    assign frame_err_pulse = ferr_q;

endmodule

// File: rtl/uart_rx_mem_loader.sv
// Receives UART bytes and writes them row-major into matrix A, then matrix B,
// with registered write strobes and a sticky framing-error flag.
module uart_rx_mem_loader
    import matmul_pkg::*;
#(
    parameter int unsigned ROWS         = 2,
    parameter int unsigned COLS         = 2,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_data,
    uart_rx_mem_loader_if.master bus
);
    localparam int unsigned N = num_elems(ROWS, COLS);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N - 1);

    if (N > 2 ** ADDR_W) begin : g_addr_check
        $error("ROWS*COLS does not fit in ADDR_W address bits");
    end
    if (CLKS_PER_BIT < 8) begin : g_baud_check
        $error("CLKS_PER_BIT must be at least 8");
    end
    if (DATA_W != 8) begin : g_width_check
        $error("DATA_W must equal the UART byte width of 8");
    end

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err_pulse;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_byte        (rx_byte),
        .byte_valid     (byte_valid),
        .frame_err_pulse(frame_err_pulse)
    );

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              wr_a_q, wr_a_d;
    logic              wr_b_q, wr_b_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LdIdle;
            count_q <= '0;
            wr_a_q  <= 1'b0;
            wr_b_q  <= 1'b0;
            addr_q  <= '0;
            value_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wr_a_q  <= wr_a_d;
            wr_b_q  <= wr_b_d;
            addr_q  <= addr_d;
            value_q <= value_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_a_d  = 1'b0;
        wr_b_d  = 1'b0;
        addr_d  = addr_q;
        value_d = value_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        unique case (state_q)
            LdIdle: begin
                if (bus.load_en) begin
                    state_d = LdLoadA;
                    count_d = '0;
                    ferr_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            LdLoadA: begin
                if (byte_valid) begin
                    wr_a_d  = 1'b1;
                    addr_d  = count_q;
                    value_d = rx_byte;
                    if (count_q == LastAddr) begin
                        count_d = '0;
                        state_d = LdLoadB;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            LdLoadB: begin
                if (byte_valid) begin
                    wr_b_d  = 1'b1;
                    addr_d  = count_q;
                    value_d = rx_byte;
                    if (count_q == LastAddr) begin
                        count_d = '0;
                        state_d = LdDone;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            LdDone: begin
                // Lands one cycle after the final B strobe, together with busy falling.
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = LdIdle;
            end
            default: state_d = LdIdle;
        endcase
        if (frame_err_pulse) ferr_d = 1'b1;
    end

    assign bus.write_A       = wr_a_q;
    assign bus.write_B       = wr_b_q;
    assign bus.write_address = addr_q;
    assign bus.write_value   = value_q;
    assign bus.load_busy     = busy_q;
    assign bus.load_done     = done_q;
    assign bus.frame_err     = ferr_q;

endmodule

// File: tb/tb_uart_rx_mem_loader.sv
// Directed bench for uart_rx_mem_loader: serial frames are driven on rx_data and
// every expected matrix write is queued, then matched against the write strobes.
module tb_uart_rx_mem_loader;
    localparam int unsigned Cpb = 16;

    logic clk;
    logic rst;
    logic rx_data;

    uart_rx_mem_loader_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    uart_rx_mem_loader #(
        .ROWS        (2),
        .COLS        (2),
        .DATA_W      (8),
        .ADDR_W      (6),
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_data(rx_data),
        .bus    (bus)
    );

    typedef struct packed {
        logic       is_b;
        logic [5:0] addr;
        logic [7:0] val;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   done_cnt   = 0;
    int   strobe_cnt = 0;
    int   s0;
    logic prev_wb    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic push(input logic is_b, input logic [5:0] addr, input logic [7:0] val);
        wr_t e;
        e.is_b = is_b;
        e.addr = addr;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Called on a falling edge; leaves the line at the end of the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_data = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_data = b[i];
            repeat (Cpb) @(negedge clk);
        end
        rx_data = stop;
        repeat (Cpb) @(negedge clk);
        rx_data = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_data = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load();
        bus.load_en = 1'b1;
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_write_A"}, bus.write_A, 0);
        check({tag, "_write_B"}, bus.write_B, 0);
        check({tag, "_write_address"}, bus.write_address, 0);
        check({tag, "_write_value"}, bus.write_value, 0);
        check({tag, "_load_busy"}, bus.load_busy, 0);
        check({tag, "_load_done"}, bus.load_done, 0);
        check({tag, "_frame_err"}, bus.frame_err, 0);
    endtask

    // Write-port monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.write_A || bus.write_B) begin
                strobe_cnt++;
                check("strobe_exclusive", bus.write_A & bus.write_B, 0);
                check("scoreboard_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("strobe_is_b", bus.write_B, mon_e.is_b);
                    check("write_address", bus.write_address, mon_e.addr);
                    check("write_value", bus.write_value, mon_e.val);
                end
            end
            if (bus.load_done) begin
                done_cnt++;
                check("done_after_last_b", prev_wb, 1);
                check("busy_low_with_done", bus.load_busy, 0);
            end
            prev_wb = bus.write_B;
        end else begin
            prev_wb = 1'b0;
        end
    end

    initial begin
        rst         = 1'b1;
        rx_data     = 1'b1;
        bus.load_en = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        s0  = strobe_cnt;
        repeat (500) @(negedge clk);
        check("quiet_after_reset", strobe_cnt - s0, 0);
        check("no_done_after_reset", done_cnt, 0);

        // Full load of A then B with back-to-back frames
        pulse_load();
        check("busy_after_load_en", bus.load_busy, 1);
        for (int i = 0; i < 8; i++) push(i >= 4, 6'(i % 4), 8'(i + 1));
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 1'b1);
        idle(Cpb);
        wait_drain("full_load_drain");
        repeat (4) @(negedge clk);
        check("full_load_done_once", done_cnt, 1);
        check("full_load_busy_low", bus.load_busy, 0);
        check("addr_holds", bus.write_address, 3);
        check("value_holds", bus.write_value, 8'h08);
        check("no_frame_err", bus.frame_err, 0);

        // Short low glitch on the line
        s0 = strobe_cnt;
        rx_data = 1'b0;
        repeat (5) @(negedge clk);
        idle(40);
        check("glitch_no_byte", strobe_cnt - s0, 0);
        check("glitch_no_err", bus.frame_err, 0);

        // Byte received while idle is dropped
        s0 = strobe_cnt;
        send_byte(8'hAA, 1'b1);
        idle(2 * Cpb);
        check("idle_drop", strobe_cnt - s0, 0);
        check("idle_not_busy", bus.load_busy, 0);
        pulse_load();
        push(1'b0, 6'd0, 8'h11);
        send_byte(8'h11, 1'b1);
        idle(Cpb);
        wait_drain("idle_then_load_drain");
        check("still_loading_a", bus.load_busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_in_load_a");
        rst = 1'b0;

        // Framing error: bad byte is discarded and the address does not advance
        pulse_load();
        push(1'b0, 6'd0, 8'h11);
        push(1'b0, 6'd1, 8'h33);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle(2 * Cpb);
        check("frame_err_set", bus.frame_err, 1);
        send_byte(8'h33, 1'b1);
        idle(Cpb);
        wait_drain("framing_drain");
        check("frame_err_sticky", bus.frame_err, 1);

        // load_en while busy must not restart or clear the error
        pulse_load();
        check("load_en_ignored_busy", bus.frame_err, 1);
        push(1'b0, 6'd2, 8'h44);
        push(1'b0, 6'd3, 8'h55);
        push(1'b1, 6'd0, 8'h66);
        push(1'b1, 6'd1, 8'h77);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        idle(Cpb);
        wait_drain("partial_b_drain");
        check("no_done_mid_b", done_cnt, 1);
        check("busy_mid_b", bus.load_busy, 1);

        // Reset after two B writes, then a complete fresh load from address 0
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_in_load_b");
        rst = 1'b0;
        @(negedge clk);
        pulse_load();
        for (int i = 0; i < 8; i++) push(i >= 4, 6'(i % 4), 8'(8'h80 + i));
        for (int i = 0; i < 8; i++) send_byte(8'(8'h80 + i), 1'b1);
        idle(Cpb);
        wait_drain("reload_drain");
        repeat (4) @(negedge clk);
        check("reload_done", done_cnt, 2);
        check("reload_busy_low", bus.load_busy, 0);
        check("reload_frame_err_clear", bus.frame_err, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
